lisnoc_vc_serializer: RTL and testbench



---
 rtl/lisnoc_vc_serializer_pkg.sv | 31 +++
 rtl/lisnoc_vc_serializer_arb_rr.sv | 28 ++
 rtl/lisnoc_vc_serializer.sv | 126 ++++++++++++
 tb/tb_lisnoc_vc_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisnoc_vc_serializer_pkg.sv
// Shared lisnoc flit definitions: field widths, flit type encodings and the
// serializer state encoding.
package lisnoc_vc_serializer_pkg;

  localparam int FLIT_DATA_WIDTH = 32;
  localparam int FLIT_TYPE_WIDTH = 2;
  localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;

  typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
    FLIT_TYPE_PAYLOAD = 2'b00,
    FLIT_TYPE_HEADER  = 2'b01,
    FLIT_TYPE_LAST    = 2'b10,
    FLIT_TYPE_SINGLE  = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } ser_state_e;

  // A flit that may open a packet (and therefore take part in arbitration).
  function automatic logic is_head(input logic [FLIT_TYPE_WIDTH-1:0] t);
    return (t == FLIT_TYPE_HEADER) || (t == FLIT_TYPE_SINGLE);
  endfunction

  // A flit that closes a packet and releases the link.
  function automatic logic is_tail(input logic [FLIT_TYPE_WIDTH-1:0] t);
    return (t == FLIT_TYPE_LAST) || (t == FLIT_TYPE_SINGLE);
  endfunction

endpackage

// File: rtl/lisnoc_vc_serializer_arb_rr.sv
// Combinational round-robin arbiter: the search starts at the requester just
// after the previous one-hot grant and wraps around.
module lisnoc_arb_rr #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] gnt_prev_i,
  output logic [N-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_prev_i[i]) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && req_i[(i + k) % N]) begin
            gnt_o[(i + k) % N] = 1'b1;
            found              = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/lisnoc_vc_serializer.sv
// Merges several virtual-channel flit streams onto one link; arbitration is
// round-robin per packet and the winner keeps the link from HEADER to LAST.
//
// Handshake: a flit moves on an interface in any cycle where valid and ready
// are both high; a source holds valid and data stable until accepted.
module lisnoc_vc_serializer
  import lisnoc_vc_serializer_pkg::*;
#(
  parameter int flit_data_width = FLIT_DATA_WIDTH,
  parameter int flit_type_width = FLIT_TYPE_WIDTH,
  parameter int vchannels       = 2,
  parameter int flit_width      = flit_data_width + flit_type_width
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [vchannels*flit_width-1:0] data_i,
  input  logic [vchannels-1:0]            valid_i,
  output logic [vchannels-1:0]            ready_o,
  output logic [flit_width-1:0]           flit_o,
  output logic                            valid_o,
  input  logic                            ready_i
);

  localparam int VCW = (vchannels > 1) ? $clog2(vchannels) : 1;
  // Pretend VC(n-1) won last so that VC0 has top priority out of reset.
  localparam logic [vchannels-1:0] PREV_RST = vchannels'(1) << (vchannels - 1);

  ser_state_e             state_q, state_d;
  logic [VCW-1:0]         cur_vc_q, cur_vc_d;
  logic [vchannels-1:0]   prev_gnt_q, prev_gnt_d;
  logic                   valid_q, valid_d;
  logic [flit_width-1:0]  flit_q, flit_d;

  logic [vchannels-1:0]   elig;
  logic [vchannels-1:0]   gnt;
  logic [vchannels-1:0]   ready;
  logic [flit_width-1:0]  sel_flit;
  logic                   accept;
  logic                   out_free;

  assign out_free = !valid_q || ready_i;

  always_comb begin
    for (int v = 0; v < vchannels; v++) begin
      elig[v] = valid_i[v] &&
                is_head(data_i[v*flit_width + flit_data_width +: flit_type_width]);
    end
  end

  lisnoc_arb_rr #(.N(vchannels)) u_arb (
    .req_i      (elig),
    .gnt_prev_i (prev_gnt_q),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d    = state_q;
    cur_vc_d   = cur_vc_q;
    prev_gnt_d = prev_gnt_q;
    ready      = '0;
    sel_flit   = '0;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|gnt) && out_free) begin
          ready      = gnt;
          accept     = 1'b1;
          prev_gnt_d = gnt;
          for (int v = 0; v < vchannels; v++) begin
            if (gnt[v]) begin
              sel_flit = data_i[v*flit_width +: flit_width];
              cur_vc_d = VCW'(v);
            end
          end
          if (sel_flit[flit_width-1 -: flit_type_width] == FLIT_TYPE_HEADER) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        // Only the locked VC is served; a stray HEADER is forwarded unchanged.
        for (int v = 0; v < vchannels; v++) begin
          if (cur_vc_q == VCW'(v)) begin
            ready[v] = out_free;
            sel_flit = data_i[v*flit_width +: flit_width];
            accept   = out_free && valid_i[v];
          end
        end
        if (accept && is_tail(sel_flit[flit_width-1 -: flit_type_width])) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    flit_d  = flit_q;
    if (out_free) begin
      valid_d = accept;
      if (accept) flit_d = sel_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_vc_q   <= '0;
      prev_gnt_q <= PREV_RST;
      valid_q    <= 1'b0;
      flit_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_vc_q   <= cur_vc_d;
      prev_gnt_q <= prev_gnt_d;
      valid_q    <= valid_d;
      flit_q     <= flit_d;
    end
  end

  assign ready_o = rst ? ready : '0;
  assign valid_o = valid_q;
  assign flit_o  = flit_q;

endmodule

// File: tb/tb_lisnoc_vc_serializer.sv
// Bench for lisnoc_vc_serializer: directed vector table, hand-written reset and
// protocol-error sequences, and randomized traffic against a queue-based model.
module tb_lisnoc_vc_serializer;

  localparam int N   = 2;
  localparam int FDW = 32;
  localparam int FW  = 34;

  localparam logic [1:0] T_PAY = 2'b00;
  localparam logic [1:0] T_HDR = 2'b01;
  localparam logic [1:0] T_LST = 2'b10;
  localparam logic [1:0] T_SGL = 2'b11;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*FW-1:0] data_i = '0;
  logic [N-1:0]    valid_i = '0;
  logic [N-1:0]    ready_o;
  logic [FW-1:0]   flit_o;
  logic            valid_o;
  logic            ready_i = 1'b0;

  always #5 clk = ~clk;

  lisnoc_vc_serializer #(
    .flit_data_width (FDW),
    .flit_type_width (2),
    .vchannels       (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .flit_o  (flit_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  // ---------------- scoreboard / model ----------------
  int n_pass   = 0;
  int n_checks = 0;
  int proto_viol = 0;

  logic [FW-1:0] exp_q[$];   // flits accepted but not yet taken downstream
  int m_lock;                // locked VC, -1 when no packet is open
  int m_last;                // last VC granted by arbitration

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  function automatic logic [1:0] ftype(input logic [FW-1:0] f);
    return f[FW-1 -: 2];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lock = -1;
    m_last = N - 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    valid_i = '1;
    data_i  = {mk(T_HDR, 32'h1111), mk(T_HDR, 32'h0000)};
    ready_i = 1'b1;
    #1 chk("rst_ready_o", ready_o, '0);
    @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_flit_o", flit_o, '0);
    model_reset();
    @(negedge clk);
    rst     = 1'b1;
    valid_i = '0;
  endtask

  // One clock of traffic: drive, check ready_o against the model, clock,
  // then check the output register against the scoreboard.
  task automatic cycle(input logic [N-1:0] v, input logic [FW-1:0] d0,
                       input logic [FW-1:0] d1, input logic rdy,
                       output logic [N-1:0] acc, output logic [N-1:0] obs_rdy);
    logic [FW-1:0] d[N];
    logic [N-1:0]  er;
    bit            free;
    @(negedge clk);
    d[0] = d0;
    d[1] = d1;
    valid_i = v;
    data_i  = {d1, d0};
    ready_i = rdy;
    #1;
    free = (exp_q.size() == 0) || rdy;
    er   = '0;
    if (m_lock >= 0) begin
      er[m_lock] = free;
    end else begin
      for (int k = 1; k <= N; k++) begin
        automatic int c = (m_last + k) % N;
        if (v[c] && (ftype(d[c]) inside {T_HDR, T_SGL})) begin
          er[c] = free;
          break;
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      if (v[c] && (ftype(d[c]) inside {T_PAY, T_LST}) && (m_lock != c)) proto_viol++;
    end
    obs_rdy = ready_o;
    chk("ready_o", ready_o, er);
    acc = er & v;
    @(posedge clk);
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    for (int c = 0; c < N; c++) begin
      if (acc[c]) begin
        exp_q.push_back(d[c]);
        if (m_lock < 0) begin
          m_last = c;
          if (ftype(d[c]) == T_HDR) m_lock = c;
        end else if (ftype(d[c]) inside {T_LST, T_SGL}) begin
          m_lock = -1;
        end
      end
    end
    #1;
    chk("valid_o", valid_o, (exp_q.size() != 0));
    if (exp_q.size() != 0) chk("flit_o", flit_o, exp_q[0]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            do_rst;
    logic [N-1:0]  v;
    logic [FW-1:0] d0;
    logic [FW-1:0] d1;
    logic          rdy;
    logic [N-1:0]  er;
    logic          ev;
    logic [FW-1:0] ef;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input logic [N-1:0] v, input logic [FW-1:0] d0,
                     input logic [FW-1:0] d1, input logic rdy, input logic [N-1:0] er,
                     input logic ev, input logic [FW-1:0] ef);
    vec_t t;
    t.do_rst = r; t.v = v; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
    t.er = er; t.ev = ev; t.ef = ef;
    vecs.push_back(t);
  endtask

  logic [FW-1:0] src_q[N][$];

  task automatic gen_pkt(input int c);
    int len = $urandom_range(0, 3);
    if (len == 0) begin
      src_q[c].push_back(mk(T_SGL, $urandom));
    end else begin
      src_q[c].push_back(mk(T_HDR, $urandom));
      for (int i = 1; i < len; i++) src_q[c].push_back(mk(T_PAY, $urandom));
      src_q[c].push_back(mk(T_LST, $urandom));
    end
  endtask

  initial begin
    logic [N-1:0]  acc, obs;
    logic [FW-1:0] H, P, L, H0, P0, L0, H1, P1, L1, Z;
    logic [N-1:0]  hold, cv;
    logic [FW-1:0] cd[N];
    int            pv0;

    Z  = '0;
    H  = mk(T_HDR, 32'h0000_0AAA);
    P  = mk(T_PAY, 32'h0000_0BBB);
    L  = mk(T_LST, 32'h0000_0CCC);
    H0 = mk(T_HDR, 32'hA000_0000); P0 = mk(T_PAY, 32'hA000_0001); L0 = mk(T_LST, 32'hA000_0002);
    H1 = mk(T_HDR, 32'hB000_0000); P1 = mk(T_PAY, 32'hB000_0001); L1 = mk(T_LST, 32'hB000_0002);

    // single VC, 1-cycle latency, valid_o exactly three cycles
    add(1, 2'b01, H,  Z, 1, 2'b01, 1, H);
    add(0, 2'b01, P,  Z, 1, 2'b01, 1, P);
    add(0, 2'b01, L,  Z, 1, 2'b01, 1, L);
    add(0, 2'b00, Z,  Z, 1, 2'b00, 0, Z);
    // two simultaneous packets: VC0 whole packet, then VC1 with no bubble
    add(1, 2'b11, H0, H1, 1, 2'b01, 1, H0);
    add(0, 2'b11, P0, H1, 1, 2'b01, 1, P0);
    add(0, 2'b11, L0, H1, 1, 2'b01, 1, L0);
    add(0, 2'b10, Z,  H1, 1, 2'b10, 1, H1);
    add(0, 2'b10, Z,  P1, 1, 2'b10, 1, P1);
    add(0, 2'b10, Z,  L1, 1, 2'b10, 1, L1);
    add(0, 2'b00, Z,  Z,  1, 2'b00, 0, Z);
    // downstream stall of four cycles mid-packet
    add(1, 2'b01, H0, Z, 1, 2'b01, 1, H0);
    for (int i = 0; i < 4; i++) add(0, 2'b01, P0, Z, 0, 2'b00, 1, H0);
    add(0, 2'b01, P0, Z, 1, 2'b01, 1, P0);
    add(0, 2'b01, L0, Z, 1, 2'b01, 1, L0);
    add(0, 2'b00, Z,  Z, 1, 2'b00, 0, Z);
    // SINGLE flits on both VCs alternate 0,1,0,1 at full rate
    add(1, 2'b11, mk(T_SGL, 32'h0A), mk(T_SGL, 32'h1A), 1, 2'b01, 1, mk(T_SGL, 32'h0A));
    add(0, 2'b11, mk(T_SGL, 32'h0B), mk(T_SGL, 32'h1A), 1, 2'b10, 1, mk(T_SGL, 32'h1A));
    add(0, 2'b11, mk(T_SGL, 32'h0B), mk(T_SGL, 32'h1B), 1, 2'b01, 1, mk(T_SGL, 32'h0B));
    add(0, 2'b11, mk(T_SGL, 32'h0C), mk(T_SGL, 32'h1B), 1, 2'b10, 1, mk(T_SGL, 32'h1B));
    add(0, 2'b00, Z, Z, 1, 2'b00, 0, Z);

    model_reset();
    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      cycle(vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].rdy, acc, obs);
      chk($sformatf("vec%0d_ready", i), obs, vecs[i].er);
      chk($sformatf("vec%0d_valid", i), valid_o, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("vec%0d_flit", i), flit_o, vecs[i].ef);
    end

    // reset in the middle of a VC1 packet, then VC0 must win re-arbitration
    do_reset();
    cycle(2'b10, Z, H1, 1, acc, obs);
    chk("mid_hdr_ready", obs, 2'b10);
    cycle(2'b10, Z, P1, 1, acc, obs);
    do_reset();
    cycle(2'b11, H0, H1, 1, acc, obs);
    chk("rst_rearb_ready", obs, 2'b01);
    chk("rst_rearb_flit", flit_o, H0);
    do_reset();

    // unlocked VC presenting PAYLOAD: ineligible, stalls, flagged
    pv0 = proto_viol;
    cycle(2'b11, mk(T_SGL, 32'h55), P1, 1, acc, obs);
    chk("proto_ready_a", obs, 2'b01);
    cycle(2'b10, Z, P1, 1, acc, obs);
    chk("proto_ready_b", obs, 2'b00);
    chk("proto_flagged", (proto_viol > pv0), 1'b1);
    do_reset();

    // randomized traffic against the model
    pv0  = proto_viol;
    hold = '0;
    cv   = '0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < N; c++) begin
        if (src_q[c].size() == 0) gen_pkt(c);
        if (!hold[c]) cv[c] = ($urandom_range(0, 3) != 0);
        cd[c] = src_q[c][0];
      end
      cycle(cv, cd[0], cd[1], ($urandom_range(0, 3) != 0), acc, obs);
      for (int c = 0; c < N; c++) begin
        if (acc[c]) void'(src_q[c].pop_front());
        hold[c] = cv[c] && !acc[c];
      end
    end
    // let the open packets finish so the sources end quiescent
    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < N; c++) begin
        cv[c] = hold[c] || (m_lock == c && src_q[c].size() != 0);
        cd[c] = (src_q[c].size() != 0) ? src_q[c][0] : Z;
      end
      cycle(cv, cd[0], cd[1], 1'b1, acc, obs);
      for (int c = 0; c < N; c++) begin
        if (acc[c]) void'(src_q[c].pop_front());
        hold[c] = cv[c] && !acc[c];
      end
    end
    chk("rand_no_proto_viol", proto_viol, pv0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
